// File: rtl/vsched_pkg.sv
// Shared types for the vector issue scheduler: queue entry, unit select and funct7 decode.
// Ports: none (package).
// The FUNCT7_* values mirror the custom-0 encodings issued by the X-IF front end.
package vsched_pkg;

  localparam logic [6:0] FUNCT7_VLD  = 7'h01;
  localparam logic [6:0] FUNCT7_VST  = 7'h02;
  localparam logic [6:0] FUNCT7_VMAC = 7'h03;

  // Entries carry the widest supported id; the top uses the low X_ID_WIDTH bits.
  localparam int unsigned ID_MAX_W = 16;

  typedef struct packed {
    logic [6:0]          funct7;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [31:0]         scalar;
    logic [ID_MAX_W-1:0] id;
  } vsched_entry_t;

  typedef enum logic [1:0] {UNIT_NONE, UNIT_LSU, UNIT_MAC} unit_e;

  function automatic unit_e decode_unit(input logic [6:0] funct7);
    unit_e u;
    case (funct7)
      FUNCT7_VLD, FUNCT7_VST: u = UNIT_LSU;
      FUNCT7_VMAC:            u = UNIT_MAC;
      default:                u = UNIT_NONE;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/vsched_if.sv
// Bundle of enqueue, LSU, MAC and retire signals between the front end / units and the scheduler.
// Ports: master = front end and execution units, slave = scheduler.
// Signal names keep the scheduler-side _i/_o direction suffixes.
interface vsched_if #(parameter int unsigned X_ID_WIDTH = 4);
  logic                  enq_valid_i;
  logic                  enq_ready_o;
  logic [6:0]            enq_funct7_i;
  logic [4:0]            enq_rd_i;
  logic [4:0]            enq_rs1_i;
  logic [4:0]            enq_rs2_i;
  logic [31:0]           enq_scalar_i;
  logic [X_ID_WIDTH-1:0] enq_id_i;
  logic                  lsu_start_o;
  logic                  lsu_store_o;
  logic [31:0]           lsu_addr_o;
  logic [4:0]            lsu_vd_o;
  logic [4:0]            lsu_vs_o;
  logic [X_ID_WIDTH-1:0] lsu_id_o;
  logic                  lsu_done_i;
  logic                  mac_start_o;
  logic [4:0]            mac_vd_o;
  logic [4:0]            mac_vs1_o;
  logic [4:0]            mac_vs2_o;
  logic [X_ID_WIDTH-1:0] mac_id_o;
  logic                  mac_done_i;
  logic                  retire_valid_o;
  logic [X_ID_WIDTH-1:0] retire_id_o;
  logic                  illegal_o;
  logic                  busy_o;

  modport master (
    output enq_valid_i, enq_funct7_i, enq_rd_i, enq_rs1_i, enq_rs2_i, enq_scalar_i, enq_id_i,
    output lsu_done_i, mac_done_i,
    input  enq_ready_o, lsu_start_o, lsu_store_o, lsu_addr_o, lsu_vd_o, lsu_vs_o, lsu_id_o,
    input  mac_start_o, mac_vd_o, mac_vs1_o, mac_vs2_o, mac_id_o,
    input  retire_valid_o, retire_id_o, illegal_o, busy_o
  );

  modport slave (
    input  enq_valid_i, enq_funct7_i, enq_rd_i, enq_rs1_i, enq_rs2_i, enq_scalar_i, enq_id_i,
    input  lsu_done_i, mac_done_i,
    output enq_ready_o, lsu_start_o, lsu_store_o, lsu_addr_o, lsu_vd_o, lsu_vs_o, lsu_id_o,
    output mac_start_o, mac_vd_o, mac_vs1_o, mac_vs2_o, mac_id_o,
    output retire_valid_o, retire_id_o, illegal_o, busy_o
  );
endinterface

// File: rtl/vsched_fifo.sv
// Purpose: DEPTH-entry synchronous FIFO of vsched_entry_t; head is the oldest entry.
// Latency: pushed entry visible at head the cycle after the push edge; no bypass.
// Backpressure: caller must not push when count==DEPTH nor pop when count==0.
// Ports: clk, rst (sync, active high), push/push_data, pop, head, count.
module vsched_fifo
  import vsched_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  vsched_entry_t push_data,
  input  logic          pop,
  output vsched_entry_t head,
  output logic [AW:0]   count
);

  vsched_entry_t mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/vector_issue_scheduler.sv
// Purpose: in-order queue dispatching custom-0 vector ops to the LSU and MAC with a VRF scoreboard.
// Latency: enqueue edge N -> start pulse in the cycle after edge N+1; retire one cycle after done.
// Backpressure: enq_ready is registered (count<DEPTH), no bypass when full; blocked head stalls all.
// Ports: clk_i/rst_i (sync, active high), bus (vsched_if.slave).
// Optional: VSCHED_PERF_EN adds perf_hazard_cycles_o, perf_struct_cycles_o, perf_dispatched_o.
module vector_issue_scheduler
  import vsched_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned NUM_VREGS  = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  vsched_if.slave     bus
`ifdef VSCHED_PERF_EN
  ,
  output logic [31:0] perf_hazard_cycles_o,
  output logic [31:0] perf_struct_cycles_o,
  output logic [31:0] perf_dispatched_o
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  vsched_entry_t enq_entry, head;
  logic [CW-1:0] count, count_next;
  logic          enq_ready_q, push, pop, head_vld, head_store;
  unit_e         head_unit;
  logic          unit_busy, sb_block, disp_lsu, disp_mac, disp_bad;
  logic          lsu_fire, mac_fire;
  logic [NUM_VREGS-1:0] sb, sb_next;

  logic                  lsu_busy, lsu_start_q, lsu_store_q;
  logic [31:0]           lsu_addr_q;
  logic [4:0]            lsu_vd_q, lsu_vs_q;
  logic [X_ID_WIDTH-1:0] lsu_id_q;
  logic                  mac_busy, mac_start_q;
  logic [4:0]            mac_vd_q, mac_vs1_q, mac_vs2_q;
  logic [X_ID_WIDTH-1:0] mac_id_q;
  logic                  retire_valid_q, pend_vld, illegal_q;
  logic [X_ID_WIDTH-1:0] retire_id_q, pend_id;
  logic                  unused_head_id;

  always_comb begin
    enq_entry        = '0;
    enq_entry.funct7 = bus.enq_funct7_i;
    enq_entry.rd     = bus.enq_rd_i;
    enq_entry.rs1    = bus.enq_rs1_i;
    enq_entry.rs2    = bus.enq_rs2_i;
    enq_entry.scalar = bus.enq_scalar_i;
    enq_entry.id[X_ID_WIDTH-1:0] = bus.enq_id_i;
  end

  assign push = bus.enq_valid_i & enq_ready_q;
  assign unused_head_id = ^head.id;

  vsched_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (enq_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Hazard checks read the scoreboard before this cycle's completions clear it,
  // so a freed register is first usable one cycle after its done.
  always_comb begin
    head_vld   = (count != '0);
    head_unit  = decode_unit(head.funct7);
    head_store = (head.funct7 == FUNCT7_VST);
    unit_busy  = 1'b0;
    sb_block   = 1'b0;
    case (head_unit)
      UNIT_LSU: begin
        unit_busy = lsu_busy;
        sb_block  = head_store ? sb[head.rs2] : sb[head.rd];
      end
      UNIT_MAC: begin
        unit_busy = mac_busy;
        sb_block  = sb[head.rs1] | sb[head.rs2] | sb[head.rd];
      end
      default: ;
    endcase
    disp_lsu   = head_vld && (head_unit == UNIT_LSU) && !unit_busy && !sb_block;
    disp_mac   = head_vld && (head_unit == UNIT_MAC) && !unit_busy && !sb_block;
    disp_bad   = head_vld && (head_unit == UNIT_NONE);
    pop        = disp_lsu | disp_mac | disp_bad;
    count_next = count + CW'(push) - CW'(pop);
  end

  assign lsu_fire = bus.lsu_done_i & lsu_busy;
  assign mac_fire = bus.mac_done_i & mac_busy;

  // Clears first, then the dispatch set, so a same-bit set wins.
  always_comb begin
    sb_next = sb;
    if (lsu_fire && !lsu_store_q) sb_next[lsu_vd_q] = 1'b0;
    if (mac_fire)                 sb_next[mac_vd_q] = 1'b0;
    if ((disp_lsu && !head_store) || disp_mac) sb_next[head.rd] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      enq_ready_q <= 1'b1;
      sb          <= '0;
      lsu_busy    <= 1'b0;  lsu_start_q <= 1'b0;  lsu_store_q <= 1'b0;
      lsu_addr_q  <= '0;    lsu_vd_q    <= '0;    lsu_vs_q    <= '0;   lsu_id_q <= '0;
      mac_busy    <= 1'b0;  mac_start_q <= 1'b0;
      mac_vd_q    <= '0;    mac_vs1_q   <= '0;    mac_vs2_q   <= '0;   mac_id_q <= '0;
      retire_valid_q <= 1'b0;  retire_id_q <= '0;
      pend_vld    <= 1'b0;  pend_id     <= '0;    illegal_q   <= 1'b0;
    end else begin
      enq_ready_q <= (count_next < CW'(DEPTH));
      sb          <= sb_next;
      lsu_start_q <= disp_lsu;
      mac_start_q <= disp_mac;
      illegal_q   <= disp_bad;

      if (disp_lsu) begin
        lsu_busy    <= 1'b1;
        lsu_store_q <= head_store;
        lsu_addr_q  <= head.scalar;
        lsu_vd_q    <= head.rd;
        lsu_vs_q    <= head.rs2;
        lsu_id_q    <= head.id[X_ID_WIDTH-1:0];
      end else if (lsu_fire) begin
        lsu_busy    <= 1'b0;
      end

      if (disp_mac) begin
        mac_busy    <= 1'b1;
        mac_vd_q    <= head.rd;
        mac_vs1_q   <= head.rs1;
        mac_vs2_q   <= head.rs2;
        mac_id_q    <= head.id[X_ID_WIDTH-1:0];
      end else if (mac_fire) begin
        mac_busy    <= 1'b0;
      end

      // LSU wins a simultaneous completion; the MAC id waits one cycle in pend.
      retire_valid_q <= pend_vld | lsu_fire | mac_fire;
      if (pend_vld)      retire_id_q <= pend_id;
      else if (lsu_fire) retire_id_q <= lsu_id_q;
      else if (mac_fire) retire_id_q <= mac_id_q;
      pend_vld <= lsu_fire & mac_fire;
      pend_id  <= mac_id_q;
    end
  end

  assign bus.enq_ready_o    = enq_ready_q;
  assign bus.lsu_start_o    = lsu_start_q;
  assign bus.lsu_store_o    = lsu_store_q;
  assign bus.lsu_addr_o     = lsu_addr_q;
  assign bus.lsu_vd_o       = lsu_vd_q;
  assign bus.lsu_vs_o       = lsu_vs_q;
  assign bus.lsu_id_o       = lsu_id_q;
  assign bus.mac_start_o    = mac_start_q;
  assign bus.mac_vd_o       = mac_vd_q;
  assign bus.mac_vs1_o      = mac_vs1_q;
  assign bus.mac_vs2_o      = mac_vs2_q;
  assign bus.mac_id_o       = mac_id_q;
  assign bus.retire_valid_o = retire_valid_q;
  assign bus.retire_id_o    = retire_id_q;
  assign bus.illegal_o      = illegal_q;
  assign bus.busy_o         = head_vld | lsu_busy | mac_busy | pend_vld;

`ifdef VSCHED_PERF_EN
  // A head waiting on a busy unit counts as structural even if it also has a data hazard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_hazard_cycles_o <= '0;
      perf_struct_cycles_o <= '0;
      perf_dispatched_o    <= '0;
    end else begin
      if (head_vld && unit_busy && (perf_struct_cycles_o != '1))
        perf_struct_cycles_o <= perf_struct_cycles_o + 32'd1;
      if (head_vld && !unit_busy && sb_block && (perf_hazard_cycles_o != '1))
        perf_hazard_cycles_o <= perf_hazard_cycles_o + 32'd1;
      if ((disp_lsu || disp_mac) && (perf_dispatched_o != '1))
        perf_dispatched_o <= perf_dispatched_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vector_issue_scheduler.sv
// Directed bench for vector_issue_scheduler: per-cycle vector table plus full-queue and reset sequences.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_vector_issue_scheduler;
  import vsched_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vsched_if #(.X_ID_WIDTH(4)) bus ();

`ifdef VSCHED_PERF_EN
  logic [31:0] perf_hazard, perf_struct, perf_disp;
`endif

  vector_issue_scheduler #(.DEPTH(4), .X_ID_WIDTH(4), .NUM_VREGS(32)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef VSCHED_PERF_EN
    ,
    .perf_hazard_cycles_o (perf_hazard),
    .perf_struct_cycles_o (perf_struct),
    .perf_dispatched_o    (perf_disp)
`endif
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic ev; logic [6:0] f7; logic [4:0] rd, rs1, rs2; logic [31:0] sc; logic [3:0] id;
    logic ld, md;
    logic ls, ms, st; logic [31:0] addr; logic [4:0] r1, r2, r3;
    logic rv; logic [3:0] rid; logic ill, bsy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    input logic ev, input logic [6:0] f7, input logic [4:0] rd, rs1, rs2,
    input logic [31:0] sc, input logic [3:0] id, input logic ld, md,
    input logic ls, ms, st, input logic [31:0] addr, input logic [4:0] r1, r2, r3,
    input logic rv, input logic [3:0] rid, input logic ill, bsy);
    vec_t v;
    v.ev = ev; v.f7 = f7; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.sc = sc; v.id = id;
    v.ld = ld; v.md = md; v.ls = ls; v.ms = ms; v.st = st; v.addr = addr;
    v.r1 = r1; v.r2 = r2; v.r3 = r3; v.rv = rv; v.rid = rid; v.ill = ill; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v, input logic [6:0] f7, input logic [4:0] rd, rs1, rs2,
                         input logic [31:0] sc, input logic [3:0] id);
    bus.enq_valid_i = v;  bus.enq_funct7_i = f7; bus.enq_rd_i = rd;
    bus.enq_rs1_i = rs1;  bus.enq_rs2_i = rs2;   bus.enq_scalar_i = sc; bus.enq_id_i = id;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ready"},  32'(bus.enq_ready_o),    32'd1);
    chk({tag, "_busy"},   32'(bus.busy_o),         32'd0);
    chk({tag, "_lstart"}, 32'(bus.lsu_start_o),    32'd0);
    chk({tag, "_lstore"}, 32'(bus.lsu_store_o),    32'd0);
    chk({tag, "_laddr"},  bus.lsu_addr_o,          32'd0);
    chk({tag, "_lvd"},    32'(bus.lsu_vd_o),       32'd0);
    chk({tag, "_lvs"},    32'(bus.lsu_vs_o),       32'd0);
    chk({tag, "_lid"},    32'(bus.lsu_id_o),       32'd0);
    chk({tag, "_mstart"}, 32'(bus.mac_start_o),    32'd0);
    chk({tag, "_mops"},   32'({bus.mac_vd_o, bus.mac_vs1_o, bus.mac_vs2_o}), 32'd0);
    chk({tag, "_mid"},    32'(bus.mac_id_o),       32'd0);
    chk({tag, "_rvalid"}, 32'(bus.retire_valid_o), 32'd0);
    chk({tag, "_rid"},    32'(bus.retire_id_o),    32'd0);
    chk({tag, "_ill"},    32'(bus.illegal_o),      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_enq(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0);
    bus.lsu_done_i = 1'b0;
    bus.mac_done_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_reset("init");

    // ev f7 rd rs1 rs2 sc id ld md | ls ms st addr r1 r2 r3 rv rid ill bsy
    // VLD v3 @0x1000 id5, then VMAC on v3 showing sb[3] cleared.
    tv.push_back(mk(1, FUNCT7_VLD, 3,0,0, 32'h1000, 5, 0,0,  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  1,0,0, 32'h1000,3,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 1,0,                  0,0,0, 0,      0,0,0, 1,5, 0,0));
    tv.push_back(mk(1, FUNCT7_VMAC, 3,3,3, 0, 6, 0,0,        0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,1,0, 0,      3,3,3, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,1,                  0,0,0, 0,      0,0,0, 1,6, 0,0));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,0));
    // VLD v1 then VMAC v2=v1*v4+v2: RAW on v1 holds MAC until two cycles after lsu_done.
    tv.push_back(mk(1, FUNCT7_VLD, 1,0,0, 32'h2000, 1, 0,0,  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(1, FUNCT7_VMAC, 2,1,4, 0, 2, 0,0,        1,0,0, 32'h2000,1,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 1,0,                  0,0,0, 0,      0,0,0, 1,1, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,1,0, 0,      2,1,4, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,1,                  0,0,0, 0,      0,0,0, 1,2, 0,0));
    // VLD v5, VST v6, VMAC v7,v8,v9: VST waits for the LSU, VMAC stays behind it, then overlaps.
    tv.push_back(mk(1, FUNCT7_VLD, 5,0,0, 32'h3000, 1, 0,0,  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(1, FUNCT7_VST, 0,0,6, 32'h4000, 2, 0,0,  1,0,0, 32'h3000,5,0,0, 0,0, 0,1));
    tv.push_back(mk(1, FUNCT7_VMAC, 7,8,9, 0, 3, 0,0,        0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 1,0,                  0,0,0, 0,      0,0,0, 1,1, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  1,0,1, 32'h4000,0,6,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,1,0, 0,      7,8,9, 0,0, 0,1));
    // Simultaneous done: LSU id 2 first, MAC id 3 next cycle.
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 1,1,                  0,0,0, 0,      0,0,0, 1,2, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 1,3, 0,0));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,0));
    // Done pulses with both units idle are ignored.
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 1,1,                  0,0,0, 0,      0,0,0, 0,0, 0,0));
    // Unknown funct7 is dropped: illegal pulse, no start, no retire.
    tv.push_back(mk(1, 7'h7F, 1,0,0, 0, 9, 0,0,              0,0,0, 0,      0,0,0, 0,0, 0,1));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 1,0));
    tv.push_back(mk(0, 0, 0,0,0, 0, 0, 0,0,                  0,0,0, 0,      0,0,0, 0,0, 0,0));

    for (int i = 0; i < tv.size(); i++) begin
      set_enq(tv[i].ev, tv[i].f7, tv[i].rd, tv[i].rs1, tv[i].rs2, tv[i].sc, tv[i].id);
      bus.lsu_done_i = tv[i].ld;
      bus.mac_done_i = tv[i].md;
      tick();
      chk($sformatf("r%0d_lstart", i), 32'(bus.lsu_start_o),    32'(tv[i].ls));
      chk($sformatf("r%0d_mstart", i), 32'(bus.mac_start_o),    32'(tv[i].ms));
      chk($sformatf("r%0d_rvalid", i), 32'(bus.retire_valid_o), 32'(tv[i].rv));
      chk($sformatf("r%0d_ill", i),    32'(bus.illegal_o),      32'(tv[i].ill));
      chk($sformatf("r%0d_busy", i),   32'(bus.busy_o),         32'(tv[i].bsy));
      chk($sformatf("r%0d_ready", i),  32'(bus.enq_ready_o),    32'd1);
      if (tv[i].ls) begin
        chk($sformatf("r%0d_laddr", i),  bus.lsu_addr_o,         tv[i].addr);
        chk($sformatf("r%0d_lvd", i),    32'(bus.lsu_vd_o),      32'(tv[i].r1));
        chk($sformatf("r%0d_lvs", i),    32'(bus.lsu_vs_o),      32'(tv[i].r2));
        chk($sformatf("r%0d_lstore", i), 32'(bus.lsu_store_o),   32'(tv[i].st));
      end
      if (tv[i].ms)
        chk($sformatf("r%0d_mops", i), 32'({bus.mac_vd_o, bus.mac_vs1_o, bus.mac_vs2_o}),
            32'({tv[i].r1, tv[i].r2, tv[i].r3}));
      if (tv[i].rv)
        chk($sformatf("r%0d_rid", i), 32'(bus.retire_id_o), 32'(tv[i].rid));
    end
    set_enq(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0);
    bus.lsu_done_i = 1'b0;
    bus.mac_done_i = 1'b0;

    // Full queue: VLD v10 occupies the LSU, VMAC reads v10, VLD v11 is WAW on the VMAC.
    set_enq(1'b1, FUNCT7_VLD, 5'd10, 5'd0, 5'd0, 32'h100, 4'd1); tick();
    set_enq(1'b1, FUNCT7_VMAC, 5'd11, 5'd10, 5'd10, 32'h0, 4'd2); tick();
    chk("full_vld_start", 32'(bus.lsu_start_o), 32'd1);
    set_enq(1'b1, FUNCT7_VLD, 5'd11, 5'd0, 5'd0, 32'h200, 4'd3); tick();
    set_enq(1'b1, FUNCT7_VST, 5'd0, 5'd0, 5'd12, 32'h300, 4'd4); tick();
    chk("full_ready_3", 32'(bus.enq_ready_o), 32'd1);
    set_enq(1'b1, FUNCT7_VLD, 5'd13, 5'd0, 5'd0, 32'h400, 4'd5); tick();
    chk("full_ready_4", 32'(bus.enq_ready_o), 32'd0);
    set_enq(1'b1, FUNCT7_VLD, 5'd14, 5'd0, 5'd0, 32'h500, 4'd6); tick();
    chk("full_hold", 32'(bus.enq_ready_o), 32'd0);
    chk("full_no_mac", 32'(bus.mac_start_o), 32'd0);
    bus.lsu_done_i = 1'b1; tick(); bus.lsu_done_i = 1'b0;
    chk("full_lsu_retire", 32'(bus.retire_valid_o), 32'd1);
    chk("full_lsu_rid", 32'(bus.retire_id_o), 32'd1);
    chk("full_ready_done", 32'(bus.enq_ready_o), 32'd0);
    chk("full_mac_wait", 32'(bus.mac_start_o), 32'd0);
    tick();
    chk("full_mac_start", 32'(bus.mac_start_o), 32'd1);
    chk("full_mac_vd", 32'(bus.mac_vd_o), 32'd11);
    chk("full_ready_pop", 32'(bus.enq_ready_o), 32'd1);
    tick();
    chk("full_fifth_in", 32'(bus.enq_ready_o), 32'd0);
    chk("full_waw_hold", 32'(bus.lsu_start_o), 32'd0);
    set_enq(1'b0, 7'h0, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0);
    tick();
    chk("mid_busy", 32'(bus.busy_o), 32'd1);

    // Reset with the MAC busy; a late mac_done must not retire.
    rst = 1'b1; tick();
    check_reset("rst");
    rst = 1'b0;
    bus.mac_done_i = 1'b1; tick(); bus.mac_done_i = 1'b0;
    chk("late_done_rvalid", 32'(bus.retire_valid_o), 32'd0);
    chk("late_done_busy", 32'(bus.busy_o), 32'd0);
    tick();
    chk("late_done_rvalid2", 32'(bus.retire_valid_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vector_issue_scheduler.md
Name: vector_issue_scheduler

Overview:
In-order instruction queue and dispatcher between the X-IF issue front end and the two vector execution resources: the load/store unit and the MAC unit.
- Buffers accepted custom-0 instructions.
- Tracks pending vector-register writes in a 32-entry scoreboard.
- Launches each instruction on its unit with a start/done handshake.
- Reports completion by X-IF id.
- Lets an LSU op and a MAC op be in flight concurrently without RAW/WAW hazards on the VRF.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
X_ID_WIDTH, 4, X-IF instruction id width
NUM_VREGS, 32, vector registers tracked by the scoreboard

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
enq_valid_i  in  1  instruction offered
enq_ready_o  out  1  queue can accept
enq_funct7_i  in  7  FUNCT7_VLD / FUNCT7_VST / FUNCT7_VMAC
enq_rd_i  in  5  vd
enq_rs1_i  in  5  vs1
enq_rs2_i  in  5  vs2 (store data for VST)
enq_scalar_i  in  32  scalar rs1 (base address)
enq_id_i  in  X_ID_WIDTH  X-IF id
lsu_start_o  out  1  one-cycle launch pulse
lsu_store_o  out  1  1=VST, 0=VLD
lsu_addr_o  out  32  base address
lsu_vd_o  out  5  load destination
lsu_vs_o  out  5  store source
lsu_id_o  out  X_ID_WIDTH  id of op in LSU
lsu_done_i  in  1  LSU completion pulse
mac_start_o  out  1  one-cycle launch pulse
mac_vd_o / mac_vs1_o / mac_vs2_o  out  5 each  MAC operands (vd is also the accumulator)
mac_id_o  out  X_ID_WIDTH  id of op in MAC
mac_done_i  in  1  MAC completion pulse
retire_valid_o  out  1  one-cycle completion pulse
retire_id_o  out  X_ID_WIDTH  id of retired op
illegal_o  out  1  pulse when an unknown funct7 is dropped
busy_o  out  1  queue non-empty, unit active, or retire pending

Behaviour:
Reset state (rst_i high at an edge): queue empty, scoreboard cleared, both units idle, retire pending cleared. Every output is 0 except enq_ready_o=1.
Enqueue:
- Fires when enq_valid_i && enq_ready_o.
- enq_ready_o = (count < DEPTH), registered; there is no bypass when full, even if a dispatch happens in the same cycle.
Head dispatch rule (evaluated on the head entry each cycle):
- VLD: needs LSU idle and sb[rd] clear.
- VST: needs LSU idle and sb[rs2] clear.
- VMAC: needs MAC idle and sb[rs1], sb[rs2], sb[rd] all clear.
- Unknown funct7: popped with no unit; illegal_o pulses next cycle; no retire.
- Strictly in order: a blocked head blocks everything behind it.
On dispatch:
- Pop the head.
- Mark the unit busy.
- Set sb[rd] for VLD/VMAC (VST sets nothing).
- Register the operands into the unit's output fields.
- Pulse start_o the next cycle.
- Operand outputs hold stable until done.
Latency: enqueue at edge N, start_o high in cycle N+2 when unhazarded.
Completion:
- done_i while the unit is busy frees the unit and clears the scoreboard bit of its vd at that edge.
- The first dispatch to the freed unit can therefore start_o two cycles after done_i.
- done_i while the unit is idle is ignored.
Retire:
- retire_valid_o is registered: one cycle after done.
- If lsu_done_i and mac_done_i arrive together, the LSU id retires first and the MAC id is held in a one-entry pending register and retires the next cycle.
- A further done arriving while pending is occupied is impossible: each unit has only one op outstanding.
Simultaneous scoreboard set and clear on the same bit: set wins. This cannot occur legally, because hazard checks use the pre-clear scoreboard.
Reset mid-operation: all state discarded; a late done_i after reset is ignored.

Optional Feature:
VSCHED_PERF_EN:
- Defined: adds outputs perf_hazard_cycles_o[31:0] (cycles the head is blocked by the scoreboard), perf_struct_cycles_o[31:0] (cycles blocked by a busy unit) and perf_dispatched_o[31:0] (ops launched).
- Counters saturate at 0xFFFFFFFF and are zeroed by rst_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vsched_pkg:
  - vsched_entry_t struct {funct7, rd, rs1, rs2, scalar, id}
  - unit_e enum {UNIT_NONE, UNIT_LSU, UNIT_MAC}
  - function decoding funct7 to unit_e, using the FUNCT7_* constants from custom_opcodes.vh
- Sub-module vsched_fifo: generic DEPTH-entry synchronous FIFO of vsched_entry_t with count, push, pop and head output.
- Scoreboard and unit trackers stay in the top module.

Test Plan:
- VLD v3 @0x1000, no stall -> lsu_start_o in cycle N+2 with addr 0x1000, vd 3; lsu_done_i -> retire_id = enq id one cycle later; sb[3] cleared.
- VLD v1 then VMAC v2=v1*v4+v2 -> MAC held until lsu_done_i; mac_start_o exactly 2 cycles after done; vs1=1, vs2=4, vd=2.
- VLD v5 then VST v6, ids 1,2 -> VST waits for LSU structural free; VMAC v7,v8,v9 enqueued behind runs concurrently only once at head.
- lsu_done_i and mac_done_i in the same cycle -> retire ids LSU then MAC on consecutive cycles.
- Enqueue 5 ops with both units blocked -> enq_ready_o low after 4 accepted; 5th accepted the cycle after the first pop frees a slot; funct7 0x7F entry -> illegal_o pulse, no start, no retire.
- rst_i asserted while MAC busy -> all outputs reset next cycle; a subsequent mac_done_i produces no retire.
